// File: rtl/axon_spike_emitter.sv
// axon_spike_emitter: transmit end of the neuron spike interface.
// Detects threshold crossings on a 10-bit membrane trace, applies a refractory
// lockout followed by re-arm hysteresis, and queues each fire as an in-flight
// spike that appears on o_Spike as a one-cycle pulse after a fixed axonal delay.
// Optional build macro AXON_SPIKE_COUNT_EN adds a saturating 16-bit count of
// emitted spikes on o_Spike_Count.
module axon_spike_emitter #(
  parameter int c_THRESHOLD   = 500,
  parameter int c_BASE        = 100,
  parameter int c_AXON_DELAY  = 8,
  parameter int c_REFRACTORY  = 16,
  parameter int c_MAX_PENDING = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [9:0]  i_PSP_Trace,
  input  logic        i_Enable,
  output logic        o_Spike,
  output logic        o_Busy,
  output logic        o_Overflow
`ifdef AXON_SPIKE_COUNT_EN
  ,
  output logic [15:0] o_Spike_Count
`endif
);

  localparam logic [9:0] c_THR_V    = 10'(c_THRESHOLD);
  localparam logic [9:0] c_BASE_V   = 10'(c_BASE);
  localparam logic [7:0] c_DLY_INIT = 8'(c_AXON_DELAY - 1);
  localparam logic [7:0] c_REF_INIT = 8'(c_REFRACTORY);
  localparam int         c_OCC_W    = $clog2(c_MAX_PENDING + 1);
  localparam logic [c_OCC_W-1:0] c_MAX_OCC = c_OCC_W'(c_MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_REFRACT    = 2'd1,
    S_WAIT_REARM = 2'd2
  } t_state;

  t_state             r_state;
  t_state             w_next_state;
  logic [7:0]         r_refr_cnt;
  logic               w_above;
  logic               w_below;
  logic               w_fire;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [c_OCC_W-1:0] r_occ;
  logic [c_OCC_W-1:0] w_occ_after_pop;
  logic [c_OCC_W-1:0] w_occ_next;
  logic [7:0]         r_q      [c_MAX_PENDING];
  logic [7:0]         w_q_next [c_MAX_PENDING];
  logic [7:0]         w_q_ext  [c_MAX_PENDING+1];
  logic               r_spike;
  logic               r_overflow;

  // Countdown step that holds at zero so an entry can never wrap.
  function automatic logic [7:0] f_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : (v - 8'd1);
  endfunction

  assign w_above = (i_PSP_Trace >= c_THR_V);
  assign w_below = (i_PSP_Trace <= c_BASE_V);

  // Detection FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Detection FSM next-state: fire from IDLE, lock out, then wait for the trace to decay.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_Enable && w_above) w_next_state = S_REFRACT;
        else                     w_next_state = S_IDLE;
      end
      S_REFRACT: begin
        if (r_refr_cnt <= 8'd1) w_next_state = S_WAIT_REARM;
        else                    w_next_state = S_REFRACT;
      end
      S_WAIT_REARM: begin
        if (w_below) w_next_state = S_IDLE;
        else         w_next_state = S_WAIT_REARM;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Detection FSM outputs: fire strobe and busy indication.
  always_comb begin
    w_fire = 1'b0;
    case (r_state)
      S_IDLE:  w_fire = i_Enable & w_above;
      default: w_fire = 1'b0;
    endcase
    o_Busy = (r_occ != '0) || (r_state != S_IDLE);
  end

  // Refractory counter: loaded on a fire, counts down while locked out.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)                                        r_refr_cnt <= 8'd0;
    else if (w_fire)                                    r_refr_cnt <= c_REF_INIT;
    else if (r_state == S_REFRACT && r_refr_cnt != 8'd0) r_refr_cnt <= r_refr_cnt - 8'd1;
    else                                                r_refr_cnt <= r_refr_cnt;
  end

  // Queue next state: pop an expired head, age the rest, append a new fire at the tail.
  always_comb begin
    w_pop           = (r_occ != '0) && (r_q[0] == 8'd0);
    w_occ_after_pop = r_occ - c_OCC_W'(w_pop);
    w_push          = w_fire && (w_occ_after_pop < c_MAX_OCC);
    w_drop          = w_fire && !w_push;
    w_occ_next      = w_occ_after_pop + c_OCC_W'(w_push);
    for (int i = 0; i < c_MAX_PENDING; i++) begin
      w_q_ext[i] = r_q[i];
    end
    w_q_ext[c_MAX_PENDING] = 8'd0;
    for (int i = 0; i < c_MAX_PENDING; i++) begin
      if ((i + int'(w_pop)) < int'(r_occ)) begin
        w_q_next[i] = f_dec(w_pop ? w_q_ext[i+1] : w_q_ext[i]);
      end else if (w_push && (i == int'(w_occ_after_pop))) begin
        w_q_next[i] = c_DLY_INIT;
      end else begin
        w_q_next[i] = 8'd0;
      end
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_occ <= '0;
      for (int i = 0; i < c_MAX_PENDING; i++) r_q[i] <= 8'd0;
    end else begin
      r_occ <= w_occ_next;
      for (int i = 0; i < c_MAX_PENDING; i++) r_q[i] <= w_q_next[i];
    end
  end

  // Registered spike pulse and sticky overflow flag.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_spike    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_spike    <= w_pop;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign o_Spike    = r_spike;
  assign o_Overflow = r_overflow;

`ifdef AXON_SPIKE_COUNT_EN
  logic [15:0] r_spike_count;

  // Saturating count of emitted spikes.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)                                  r_spike_count <= 16'd0;
    else if (r_spike && r_spike_count != 16'hFFFF) r_spike_count <= r_spike_count + 16'd1;
    else                                          r_spike_count <= r_spike_count;
  end

  assign o_Spike_Count = r_spike_count;
`endif

endmodule

// File: tb/tb_axon_spike_emitter.sv
// Self-checking bench for axon_spike_emitter. Two instances: default
// parameters (index 0) and a long-delay / short-lockout / shallow-queue
// configuration (index 1). A timestamp-based reference model predicts outputs.
module tb_axon_spike_emitter;

  logic       clk;
  logic       rst0, en0, rst1, en1;
  logic [9:0] tr0, tr1;
  logic       spk0, busy0, ovf0, spk1, busy1, ovf1;
`ifdef AXON_SPIKE_COUNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  axon_spike_emitter u_dut0 (
    .i_Clk(clk), .i_Reset(rst0), .i_PSP_Trace(tr0), .i_Enable(en0),
    .o_Spike(spk0), .o_Busy(busy0), .o_Overflow(ovf0)
`ifdef AXON_SPIKE_COUNT_EN
    , .o_Spike_Count(cnt0)
`endif
  );

  axon_spike_emitter #(
    .c_THRESHOLD(500), .c_BASE(100), .c_AXON_DELAY(40),
    .c_REFRACTORY(1), .c_MAX_PENDING(2)
  ) u_dut1 (
    .i_Clk(clk), .i_Reset(rst1), .i_PSP_Trace(tr1), .i_Enable(en1),
    .o_Spike(spk1), .o_Busy(busy1), .o_Overflow(ovf1)
`ifdef AXON_SPIKE_COUNT_EN
    , .o_Spike_Count(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 armed, 1 locked out until lock_until, 2 waiting for decay.
  // Queue holds the absolute edge index at which each accepted spike is due.
  int P_D [2] = '{8, 40};
  int P_R [2] = '{16, 1};
  int P_M [2] = '{4, 2};
  int mode [2] = '{0, 0};
  int lock_until [2] = '{0, 0};
  int qn [2] = '{0, 0};
  int qd [2][16];
  int t = 0;
  bit exp_spike [2] = '{1'b0, 1'b0};
  bit exp_busy  [2] = '{1'b0, 1'b0};
  bit exp_ovf   [2] = '{1'b0, 1'b0};
  int exp_cnt   [2] = '{0, 0};

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        bit r_s, e_s, fire;
        int tr_s;
        r_s  = (k == 0) ? rst0 : rst1;
        e_s  = (k == 0) ? en0 : en1;
        tr_s = (k == 0) ? int'(tr0) : int'(tr1);
        if (exp_spike[k] && exp_cnt[k] < 65535) exp_cnt[k]++;
        if (r_s) begin
          mode[k] = 0; qn[k] = 0; exp_ovf[k] = 1'b0;
          exp_spike[k] = 1'b0; exp_cnt[k] = 0;
        end else begin
          exp_spike[k] = 1'b0;
          if (qn[k] > 0 && qd[k][0] == t) begin
            exp_spike[k] = 1'b1;
            for (int m = 0; m < 15; m++) qd[k][m] = qd[k][m+1];
            qn[k]--;
          end
          fire = 1'b0;
          if (mode[k] == 0) begin
            if (e_s && tr_s >= 500) fire = 1'b1;
          end else if (mode[k] == 1) begin
            if (t >= lock_until[k]) mode[k] = 2;
          end else begin
            if (tr_s <= 100) mode[k] = 0;
          end
          if (fire) begin
            mode[k] = 1;
            lock_until[k] = t + P_R[k];
            if (qn[k] < P_M[k]) begin
              qd[k][qn[k]] = t + P_D[k];
              qn[k]++;
            end else begin
              exp_ovf[k] = 1'b1;
            end
          end
        end
        exp_busy[k] = (qn[k] > 0) || (mode[k] != 0);
      end
      t++;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b1; tr0 = 10'd50; tr1 = 10'd50;
    repeat (3) @(negedge clk);
    checks++;
    if ({spk0, busy0, ovf0} !== 3'b000) begin
      errors++; $display("FAIL reset_dut0: got %b required 000", {spk0, busy0, ovf0});
    end
    checks++;
    if ({spk1, busy1, ovf1} !== 3'b000) begin
      errors++; $display("FAIL reset_dut1: got %b required 000", {spk1, busy1, ovf1});
    end
`ifdef AXON_SPIKE_COUNT_EN
    checks++;
    if (cnt0 !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d required 0", cnt0);
    end
`endif
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_quiet();
    int active = 0;
    tr0 = 10'd100;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (spk0 || busy0 || ovf0) active++;
    end
    checks++;
    if (active != 0) begin
      errors++; $display("FAIL quiet_trace100: got %0d active cycles required 0", active);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    int first_j = -1;
    tr0 = 10'd500;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (spk0 === 1'b1) begin
        pulses++;
        if (first_j < 0) first_j = j;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL step_pulse_count: got %0d required 1", pulses);
    end
    checks++;
    if (first_j != 9) begin
      errors++; $display("FAIL step_latency: got pulse at cycle %0d required 9", first_j);
    end
    tr0 = 10'd50;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_rearm();
    int pulses = 0;
    int pj [2] = '{-1, -1};
    for (int j = 1; j <= 141; j++) begin
      tr0 = (j == 101) ? 10'd90 : 10'd520;
      @(negedge clk);
      if (spk0 === 1'b1) begin
        if (pulses < 2) pj[pulses] = j;
        pulses++;
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL rearm_pulse_count: got %0d required 2", pulses);
    end
    checks++;
    if (pj[0] != 9 || pj[1] != 110) begin
      errors++; $display("FAIL rearm_timing: got %0d,%0d required 9,110", pj[0], pj[1]);
    end
    tr0 = 10'd50;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_overflow();
    int pulses = 0;
    int pj [2] = '{-1, -1};
    checks++;
    if (ovf1 !== 1'b0) begin
      errors++; $display("FAIL ovf_initial: got %b required 0", ovf1);
    end
    for (int j = 1; j <= 70; j++) begin
      if (j <= 9) tr1 = ((j % 3) == 0) ? 10'd50 : 10'd600;
      else        tr1 = 10'd50;
      @(negedge clk);
      if (spk1 === 1'b1) begin
        if (pulses < 2) pj[pulses] = j;
        pulses++;
      end
      if (j == 10) begin
        checks++;
        if (ovf1 !== 1'b1) begin
          errors++; $display("FAIL ovf_set: got %b required 1", ovf1);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL ovf_pulse_count: got %0d required 2", pulses);
    end
    checks++;
    if (pj[0] != 41 || pj[1] != 44) begin
      errors++; $display("FAIL ovf_latency: got %0d,%0d required 41,44", pj[0], pj[1]);
    end
    checks++;
    if (ovf1 !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b required 1", ovf1);
    end
  endtask

  task automatic test_reset_inflight();
    int pulses = 0;
    tr0 = 10'd500;
    @(negedge clk);
    tr0 = 10'd50;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    checks++;
    if ({spk0, busy0, ovf0} !== 3'b000) begin
      errors++; $display("FAIL inflight_reset_outputs: got %b required 000", {spk0, busy0, ovf0});
    end
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (spk0 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL inflight_discarded: got %0d pulses required 0", pulses);
    end
    tr0 = 10'd500;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (spk0 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL inflight_after_reset: got %0d pulses required 1", pulses);
    end
    tr0 = 10'd50;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        int sel;
        logic [9:0] v;
        sel = int'($urandom_range(0, 9));
        if (sel < 3)       v = 10'($urandom_range(0, 100));
        else if (sel < 5)  v = 10'($urandom_range(101, 499));
        else if (sel < 8)  v = 10'($urandom_range(500, 1023));
        else if (sel == 8) v = ($urandom_range(0, 1) == 0) ? 10'd100 : 10'd101;
        else               v = ($urandom_range(0, 1) == 0) ? 10'd500 : 10'd499;
        if (k == 0) begin
          tr0 = v; en0 = ($urandom_range(0, 4) != 0); rst0 = ($urandom_range(0, 499) == 0);
        end else begin
          tr1 = v; en1 = ($urandom_range(0, 4) != 0); rst1 = ($urandom_range(0, 499) == 0);
        end
      end
      @(negedge clk);
      checks++;
      if ({spk0, busy0, ovf0} !== {exp_spike[0], exp_busy[0], exp_ovf[0]}) begin
        errors++;
        if (bad < 10) $display("FAIL rand_dut0 cycle %0d: got spk/busy/ovf %b required %b",
                               c, {spk0, busy0, ovf0}, {exp_spike[0], exp_busy[0], exp_ovf[0]});
        bad++;
      end
      checks++;
      if ({spk1, busy1, ovf1} !== {exp_spike[1], exp_busy[1], exp_ovf[1]}) begin
        errors++;
        if (bad < 10) $display("FAIL rand_dut1 cycle %0d: got spk/busy/ovf %b required %b",
                               c, {spk1, busy1, ovf1}, {exp_spike[1], exp_busy[1], exp_ovf[1]});
        bad++;
      end
`ifdef AXON_SPIKE_COUNT_EN
      checks++;
      if (int'(cnt0) != exp_cnt[0] || int'(cnt1) != exp_cnt[1]) begin
        errors++;
        if (bad < 10) $display("FAIL rand_count cycle %0d: got %0d,%0d required %0d,%0d",
                               c, cnt0, cnt1, exp_cnt[0], exp_cnt[1]);
        bad++;
      end
`endif
    end
    rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b1; en1 = 1'b1; tr0 = 10'd50; tr1 = 10'd50;
    repeat (60) @(negedge clk);
  endtask

`ifdef AXON_SPIKE_COUNT_EN
  task automatic test_count();
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    for (int f = 0; f < 5; f++) begin
      tr0 = 10'd600;
      @(negedge clk);
      tr0 = 10'd50;
      repeat (30) @(negedge clk);
    end
    checks++;
    if (cnt0 !== 16'd5) begin
      errors++; $display("FAIL count_five: got %0d required 5", cnt0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_quiet();
    test_step();
    test_rearm();
    test_overflow();
    test_reset_inflight();
    test_random();
`ifdef AXON_SPIKE_COUNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
